servo_cmd_ctrl: RTL and testbench
=================================

SERVO_CMD_CTRL -- requirements
Module: servo_cmd_ctrl

Interface
REQ-001 SHALL have parameter HDR, default 8'h53, frame header byte.
REQ-002 SHALL have parameter PW_MIN, default 24'd27027, lowest accepted pulse width in clk cycles.
REQ-003 SHALL have parameter PW_MAX, default 24'd108108, highest accepted pulse width in clk cycles.
REQ-004 SHALL have parameter PW_RST, default 24'd54054, pulse width after reset.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 24'd2_700_000, inter-byte timeout in clk cycles.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe marking a received byte.
REQ-009 SHALL have port rx_data, input, 8, received byte; qualified by rx_valid.
REQ-010 SHALL have port tx_valid, output, 1, response byte pending.
REQ-011 SHALL have port tx_data, output, 8, response byte.
REQ-012 SHALL have port tx_ready, input, 1, transmitter accepts when tx_valid and tx_ready are both high.
REQ-013 SHALL have port pw_out, output, 24, pulse width driven to the servo PWM generator.
REQ-014 SHALL have port pw_upd, output, 1, one-cycle pulse when pw_out changes.
REQ-015 SHALL have port err_cnt, output, 8, count of rejected frames; saturates at 255.

Function
REQ-016 SHALL parse frames of 5 bytes: HDR, P2, P1, P0 (24-bit width, MSB first), CK = P2^P1^P0.
REQ-017 SHALL use FSM states IDLE, PAYLOAD, CHECK, RESP.
REQ-018 SHALL, in IDLE, discard non-HDR bytes silently and enter PAYLOAD on HDR.
REQ-019 SHALL, in PAYLOAD, shift each byte into a 24-bit register with a 2-bit index 0..2; a byte equal to HDR is treated as data.
REQ-020 SHALL go to CHECK on the checksum byte; CHECK lasts exactly one cycle.
REQ-021 SHALL, on a checksum match, clamp the width to [PW_MIN,PW_MAX], load pw_out, and pulse pw_upd on the cycle after CHECK.
REQ-022 SHALL, on a match, respond 8'h4B ('K'), or 8'h43 ('C') if clamping occurred.
REQ-023 SHALL, on a checksum mismatch, respond 8'h45 ('E'), leave pw_out unchanged, and increment err_cnt.
REQ-024 SHALL assert tx_valid with stable tx_data in RESP until the tx_valid && tx_ready cycle, then return to IDLE.
REQ-025 SHALL ignore rx_valid bytes arriving during CHECK and RESP; there is no buffering.
REQ-026 SHALL make the frame-to-response latency from checksum rx_valid to first tx_valid exactly 2 cycles.
REQ-027 SHALL keep pw_out constant except on pw_upd cycles.

Reset
REQ-028 SHALL, while resetn=0, immediately force state=IDLE, pw_out=PW_RST, pw_upd=0, tx_valid=0, tx_data=0, err_cnt=0, and clear the shift register, index and timer.
REQ-029 SHALL abort any partial frame or pending response on reset mid-frame, with no response sent after release.

Configuration
REQ-030 SHALL implement an inter-byte timeout under macro SERVO_CMD_TIMEOUT_EN.
REQ-031 SHALL, with the macro defined, count cycles in PAYLOAD since the last byte; at TIMEOUT_CYC, return to IDLE, increment err_cnt, and send no response.
REQ-032 SHALL, with the macro defined, let a byte arriving on the timeout cycle win: the frame continues and the timer reloads.
REQ-033 SHALL, without the macro, synthesize no timer and wait in PAYLOAD indefinitely.

Structure
REQ-034 SHALL place the state encoding, response codes 'K'/'C'/'E' and the frame length in package servo_cmd_pkg.
REQ-035 SHALL implement the clamp and response-code selection in sub-module servo_pw_clamp (combinational; 24-bit in; 24-bit out plus clamped flag).

Verification
REQ-036 SHALL verify: frame 53 00 D3 56 85 -> pw_out=54102, one pw_upd pulse, tx_data=4B.
REQ-037 SHALL verify: frame 53 00 00 10 10 -> pw_out=27027, tx_data=43.
REQ-038 SHALL verify: frame 53 00 D3 56 00 -> tx_data=45, pw_out unchanged, err_cnt=1.
REQ-039 SHALL verify: tx_ready held low for 50 cycles in RESP with a new frame sent meanwhile -> tx_data stable, frame ignored, a single response.
REQ-040 SHALL verify: resetn low after 53 00 -> pw_out=54054, tx_valid=0; a full valid frame after release is accepted.
REQ-041 SHALL verify, with SERVO_CMD_TIMEOUT_EN: 53 00 then idle for TIMEOUT_CYC -> IDLE, err_cnt=1, no tx_valid.

Source files
------------

// File: rtl/servo_cmd_pkg.sv
// -----------------------------------------------------------------------------
// servo_cmd_pkg
// Shared definitions for the servo command controller: parser FSM encoding,
// response codes, frame geometry and the payload checksum helper.
// -----------------------------------------------------------------------------
package servo_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K' accepted as sent
    localparam logic [7:0] RSP_CLAMP = 8'h43;  // 'C' accepted after clamping
    localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E' checksum mismatch

    // HDR + three payload bytes + checksum
    localparam int FRAME_LEN = 5;

    // Byte index (after the header) at which the checksum arrives
    localparam logic [1:0] CK_IDX = 2'(FRAME_LEN - 2);

    function automatic logic [7:0] frame_ck(input logic [23:0] p);
        return p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

endpackage

// File: rtl/servo_pw_clamp.sv
// -----------------------------------------------------------------------------
// servo_pw_clamp
// Combinational clamp of a requested pulse width into [PW_MIN, PW_MAX] and
// selection of the response code for the frame.
// Ports:
//   i_pw      requested 24-bit pulse width
//   i_ck_ok   frame checksum matched
//   o_pw      clamped pulse width
//   o_clamped request was outside the legal range
//   o_code    response byte: 'E' on bad checksum, else 'C' if clamped, else 'K'
// -----------------------------------------------------------------------------
module servo_pw_clamp
    import servo_cmd_pkg::*;
#(
    parameter logic [23:0] PW_MIN = 24'd27027,
    parameter logic [23:0] PW_MAX = 24'd108108
) (
    input  logic [23:0] i_pw,
    input  logic        i_ck_ok,
    output logic [23:0] o_pw,
    output logic        o_clamped,
    output logic [7:0]  o_code
);

    always_comb begin
        o_pw      = i_pw;
        o_clamped = 1'b0;
        if (i_pw < PW_MIN) begin
            o_pw      = PW_MIN;
            o_clamped = 1'b1;
        end else if (i_pw > PW_MAX) begin
            o_pw      = PW_MAX;
            o_clamped = 1'b1;
        end
        if (!i_ck_ok)       o_code = RSP_ERR;
        else if (o_clamped) o_code = RSP_CLAMP;
        else                o_code = RSP_OK;
    end

endmodule

// File: rtl/servo_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// servo_cmd_ctrl
// Parses 5-byte servo frames (HDR, P2, P1, P0, P2^P1^P0) from a byte stream,
// loads the clamped pulse width and returns a one-byte response.
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   rx_valid, rx_data    received byte strobe and data
//   tx_valid, tx_data    response byte, held until tx_ready
//   tx_ready             transmitter accept
//   pw_out, pw_upd       pulse width to the PWM generator and its load pulse
//   err_cnt              rejected frames (bad checksum or timeout), saturating
// Build option:
//   SERVO_CMD_TIMEOUT_EN adds an inter-byte timeout in PAYLOAD (TIMEOUT_CYC).
// -----------------------------------------------------------------------------
module servo_cmd_ctrl
    import servo_cmd_pkg::*;
#(
    parameter logic [7:0]  HDR         = 8'h53,
    parameter logic [23:0] PW_MIN      = 24'd27027,
    parameter logic [23:0] PW_MAX      = 24'd108108,
    parameter logic [23:0] PW_RST      = 24'd54054,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2_700_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [23:0] pw_out,
    output logic        pw_upd,
    output logic [7:0]  err_cnt
);

    state_t      r_state, w_next;
    logic [23:0] r_shift;
    logic [1:0]  r_idx;
    logic [7:0]  r_ck;
    logic [23:0] r_pw;
    logic        r_upd;
    logic        r_txv;
    logic [7:0]  r_txd;
    logic [7:0]  r_err;

    logic        w_ck_ok;
    logic [23:0] w_pw_clamped;
    logic        w_clamped;
    logic [7:0]  w_code;
    logic        w_timeout;
    logic [7:0]  w_err_inc;

    assign w_ck_ok   = (frame_ck(r_shift) == r_ck);
    assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

`ifdef SERVO_CMD_TIMEOUT_EN
    // Cycles in PAYLOAD since the last byte; a byte on the expiry cycle
    // takes priority and reloads the count.
    logic [23:0] r_timer;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                              r_timer <= '0;
        else if (r_state != ST_PAYLOAD || rx_valid) r_timer <= '0;
        else                                      r_timer <= r_timer + 24'd1;
    end

    assign w_timeout = (r_state == ST_PAYLOAD) && !rx_valid &&
                       (r_timer == TIMEOUT_CYC - 24'd1);
`else
    // No timer in this build; the parameter stays on the interface only.
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYC;
    assign w_timeout    = 1'b0;
`endif

    servo_pw_clamp #(
        .PW_MIN (PW_MIN),
        .PW_MAX (PW_MAX)
    ) u_clamp (
        .i_pw      (r_shift),
        .i_ck_ok   (w_ck_ok),
        .o_pw      (w_pw_clamped),
        .o_clamped (w_clamped),
        .o_code    (w_code)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (rx_valid && rx_data == HDR) w_next = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (rx_valid && r_idx == CK_IDX) w_next = ST_CHECK;
                else if (w_timeout)              w_next = ST_IDLE;
            end
            ST_CHECK:   w_next = ST_RESP;
            ST_RESP:    if (r_txv && tx_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_ck    <= '0;
            r_pw    <= PW_RST;
            r_upd   <= 1'b0;
            r_txv   <= 1'b0;
            r_txd   <= '0;
            r_err   <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && rx_data == HDR) begin
                        r_shift <= '0;
                        r_idx   <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        if (r_idx == CK_IDX) r_ck <= rx_data;
                        else                 r_shift <= {r_shift[15:0], rx_data};
                        r_idx <= r_idx + 2'd1;
                    end else if (w_timeout) begin
                        r_err <= w_err_inc;
                    end
                end
                ST_CHECK: begin
                    // Response and new width become visible together, two
                    // cycles after the checksum strobe.
                    r_txv <= 1'b1;
                    r_txd <= w_code;
                    if (w_ck_ok) begin
                        r_pw  <= w_pw_clamped;
                        r_upd <= 1'b1;
                    end else begin
                        r_err <= w_err_inc;
                    end
                end
                ST_RESP: begin
                    if (r_txv && tx_ready) r_txv <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign tx_valid = r_txv;
    assign tx_data  = r_txd;
    assign pw_out   = r_pw;
    assign pw_upd   = r_upd;
    assign err_cnt  = r_err;

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servo_cmd_ctrl
// Scoreboarded bench: the stimulus process pushes the expected response of
// every frame it sends; a monitor pops on each tx handshake and compares the
// response byte, pulse width and error count. It also watches response
// latency, tx hold while stalled, and that pw_out only moves with pw_upd.
// -----------------------------------------------------------------------------
module tb_servo_cmd_ctrl;

    localparam logic [7:0]  HDR    = 8'h53;
    localparam logic [23:0] PW_MIN = 24'd27027;
    localparam logic [23:0] PW_MAX = 24'd108108;
    localparam logic [23:0] PW_RST = 24'd54054;
    localparam logic [23:0] TMO    = 24'd300;

    typedef struct {
        logic [7:0]  code;
        logic [23:0] pw;
        logic [7:0]  err;
        int          ckcyc;
    } exp_t;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid, pw_upd;
    logic [7:0]  tx_data, err_cnt;
    logic [23:0] pw_out;

    int          n_vec = 0, n_mis = 0, cyc = 0, upd_seen = 0, m_upd = 0;
    logic [23:0] m_pw  = PW_RST;
    logic [7:0]  m_err = 8'h00;
    bit          rdy_force = 1'b0, rdy_val = 1'b0;
    exp_t        q[$];

    servo_cmd_ctrl #(
        .HDR(HDR), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_RST(PW_RST), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .pw_out(pw_out), .pw_upd(pw_upd), .err_cnt(err_cnt)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        tx_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with rx_valid low.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] xor3(input logic [23:0] p);
        return p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

    // Sends a full frame with 'gap' idle cycles before each byte after the
    // header; if push, the reference outcome is queued for the monitor.
    task automatic send_frame(input logic [23:0] p, input logic [7:0] ck,
                              input bit push, input int gap);
        exp_t e;
        int   ckc;
        send_byte(HDR);
        repeat (gap) @(negedge clk);
        send_byte(p[23:16]);
        repeat (gap) @(negedge clk);
        send_byte(p[15:8]);
        repeat (gap) @(negedge clk);
        send_byte(p[7:0]);
        repeat (gap) @(negedge clk);
        ckc = cyc;
        send_byte(ck);
        if (push) begin
            if (ck == xor3(p)) begin
                if (p < PW_MIN)      begin m_pw = PW_MIN; e.code = 8'h43; end
                else if (p > PW_MAX) begin m_pw = PW_MAX; e.code = 8'h43; end
                else                 begin m_pw = p;      e.code = 8'h4B; end
                m_upd++;
            end else begin
                e.code = 8'h45;
                if (m_err != 8'd255) m_err = m_err + 8'd1;
            end
            e.pw    = m_pw;
            e.err   = m_err;
            e.ckcyc = ckc;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL resp_timeout: %0d pending, want 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_txv();
        int n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("txv_seen", {31'd0, tx_valid}, 32'd1);
    endtask

    // Monitor
    initial begin
        logic [23:0] prev_pw = PW_RST;
        logic [7:0]  prev_d  = 8'h00;
        bit          prev_v  = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_pw = pw_out;
                prev_v  = 1'b0;
            end else begin
                if (pw_upd) upd_seen++;
                else        chk("pw_hold", pw_out, prev_pw);
                if (prev_v) begin
                    chk("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
                    chk("tx_data_hold", tx_data, prev_d);
                end else if (tx_valid) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_mis++;
                        $display("FAIL unexpected_tx: got %0h want none", tx_data);
                    end else begin
                        chk("latency", cyc - q[0].ckcyc, 32'd2);
                    end
                end
                if (tx_valid && tx_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("tx_data", tx_data, e.code);
                    chk("pw_out", pw_out, e.pw);
                    chk("err_cnt", err_cnt, e.err);
                end
                prev_v  = tx_valid && !tx_ready;
                prev_pw = pw_out;
                prev_d  = tx_data;
            end
        end
    end

    // Stimulus
    initial begin
        logic [23:0] bnd[6];
        logic [23:0] p;
        logic [7:0]  ck, b;

        repeat (2) @(negedge clk);
        chk("rst_pw", pw_out, PW_RST);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_upd", {31'd0, pw_upd}, 32'd0);
        chk("rst_err", err_cnt, 8'h00);
        @(posedge clk); #2 resetn = 1'b1;
        @(negedge clk);

        send_frame(24'h00D356, 8'h85, 1'b1, 0); wait_idle();
        chk("ok_pw", pw_out, 24'd54102);
        send_frame(24'h000010, 8'h10, 1'b1, 1); wait_idle();
        chk("clamp_pw", pw_out, 24'd27027);
        send_frame(24'h00D356, 8'h00, 1'b1, 0); wait_idle();
        chk("bad_err", err_cnt, 8'd1);
        chk("bad_pw", pw_out, 24'd27027);

        bnd[0] = PW_MIN; bnd[1] = PW_MAX; bnd[2] = PW_MAX + 24'd1;
        bnd[3] = PW_MIN - 24'd1; bnd[4] = 24'hFFFFFF; bnd[5] = 24'h535353;
        foreach (bnd[i]) begin
            send_frame(bnd[i], xor3(bnd[i]), 1'b1, 0);
            wait_idle();
        end

        // Stalled response with a second frame arriving during RESP
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        send_frame(24'h010000, xor3(24'h010000), 1'b1, 0);
        wait_txv();
        send_frame(24'h00C000, xor3(24'h00C000), 1'b0, 0);
        repeat (40) @(negedge clk);
        chk("stall_txv", {31'd0, tx_valid}, 32'd1);
        rdy_val = 1'b1;
        wait_idle();
        rdy_force = 1'b0;
        repeat (20) @(negedge clk);
        chk("single_resp", {31'd0, tx_valid}, 32'd0);
        chk("stall_pw", pw_out, 24'h010000);

        for (int i = 0; i < 40; i++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                send_byte(b);
            end
            case ($urandom_range(0, 3))
                0:       p = 24'($urandom_range(0, 32'(PW_MIN)));
                1:       p = 24'($urandom_range(32'(PW_MIN), 32'(PW_MAX)));
                2:       p = 24'($urandom_range(32'(PW_MAX), 32'hFFFFFF));
                default: p = 24'($urandom);
            endcase
            ck = xor3(p);
            if ($urandom_range(0, 3) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
            send_frame(p, ck, 1'b1, $urandom_range(0, 2));
            wait_idle();
        end

        // Reset in the middle of a frame
        send_byte(HDR);
        send_byte(8'h00);
        @(posedge clk); #2 resetn = 1'b0;
        m_pw  = PW_RST;
        m_err = 8'h00;
        @(negedge clk);
        chk("midrst_pw", pw_out, PW_RST);
        chk("midrst_txv", {31'd0, tx_valid}, 32'd0);
        chk("midrst_err", err_cnt, 8'h00);
        @(posedge clk); #2 resetn = 1'b1;
        @(negedge clk);
        send_frame(24'h00A000, xor3(24'h00A000), 1'b1, 0); wait_idle();
        chk("postrst_pw", pw_out, 24'h00A000);

        // Reset while a response is pending
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        send_frame(24'h00B000, xor3(24'h00B000), 1'b1, 0);
        wait_txv();
        @(posedge clk); #2 resetn = 1'b0;
        q.delete();
        m_pw  = PW_RST;
        m_err = 8'h00;
        @(negedge clk);
        chk("resprst_txv", {31'd0, tx_valid}, 32'd0);
        chk("resprst_pw", pw_out, PW_RST);
        @(posedge clk); #2 resetn = 1'b1;
        rdy_force = 1'b0;
        repeat (10) @(negedge clk);
        chk("resprst_quiet", {31'd0, tx_valid}, 32'd0);

`ifdef SERVO_CMD_TIMEOUT_EN
        send_byte(HDR);
        send_byte(8'h00);
        repeat (int'(TMO) + 5) @(negedge clk);
        m_err = m_err + 8'd1;
        chk("tmo_err", err_cnt, m_err);
        chk("tmo_txv", {31'd0, tx_valid}, 32'd0);
        // Every byte lands exactly on the expiry cycle and must win
        send_frame(24'h00E000, xor3(24'h00E000), 1'b1, int'(TMO) - 1);
        wait_idle();
        chk("tmo_edge_pw", pw_out, 24'h00E000);
        chk("tmo_edge_err", err_cnt, m_err);
`endif

        repeat (5) @(negedge clk);
        chk("upd_count", upd_seen, m_upd);
        chk("q_empty", q.size(), 32'd0);
        chk("end_txv", {31'd0, tx_valid}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
